// File: rtl/even_count_monitor_if.sv
// even_count_monitor_if: counter sample bus and monitor status outputs
// master: drives counter bits A..D and direction y, reads status
// slave:  the monitor; reads A..D/y, drives odd_err, step_err, wrap_up, wrap_down, err_count, fault
interface even_count_monitor_if;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic       y;
  logic       odd_err;
  logic       step_err;
  logic       wrap_up;
  logic       wrap_down;
  logic [3:0] err_count;
  logic       fault;
  modport master (output A, B, C, D, y, input odd_err, step_err, wrap_up, wrap_down, err_count, fault);
  modport slave (input A, B, C, D, y, output odd_err, step_err, wrap_up, wrap_down, err_count, fault);
endinterface

// File: rtl/even_count_monitor.sv
// even_count_monitor: checks that a 4-bit even counter moves by legal +/-2 steps
// clock     : system clock, rising edge
// reset     : synchronous active-high reset
// bus.A..D  : sampled count {A,B,C,D}; y is the direction presented this cycle
// bus.*_err : one-cycle registered error flags; wrap_up/wrap_down one-cycle legal wrap pulses
// err_count : saturating error tally; fault is sticky after three consecutive bad steps
module even_count_monitor (
  input logic             clock,
  input logic             reset,
  even_count_monitor_if.slave bus
);
  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;
  state_t     r_state;
  logic [3:0] r_prev;
  logic       r_prev_y;
  logic [1:0] r_consec;
  logic [3:0] r_err_count;
  logic       r_odd_err;
  logic       r_step_err;
  logic       r_wrap_up;
  logic       r_wrap_down;
  logic       r_fault;
  logic [3:0] w_cnt;
  logic [3:0] w_exp;
  logic       w_step;
  logic       w_err;
  assign w_cnt  = {bus.A, bus.B, bus.C, bus.D};
  // the step is judged against the direction sampled on the previous edge
  assign w_exp  = r_prev_y ? r_prev + 4'd2 : r_prev - 4'd2;
  assign w_step = w_cnt != w_exp;
  assign w_err  = w_step | bus.D;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= INIT;
      r_prev      <= '0;
      r_prev_y    <= 1'b0;
      r_consec    <= '0;
      r_err_count <= '0;
      r_odd_err   <= 1'b0;
      r_step_err  <= 1'b0;
      r_wrap_up   <= 1'b0;
      r_wrap_down <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_prev    <= w_cnt;
          r_prev_y  <= bus.y;
          r_odd_err <= bus.D;
          r_state   <= TRACK;
        end
        TRACK: begin
          r_step_err  <= w_step;
          r_odd_err   <= bus.D;
          r_wrap_up   <= !w_err && r_prev_y && r_prev == 4'd14 && w_cnt == 4'd0;
          r_wrap_down <= !w_err && !r_prev_y && r_prev == 4'd0 && w_cnt == 4'd14;
          // prev always follows the real count so one glitch costs one error
          r_prev      <= w_cnt;
          r_prev_y    <= bus.y;
          r_err_count <= r_err_count + {3'b0, w_err && r_err_count != 4'hf};
          r_consec    <= w_err ? r_consec + 2'd1 : 2'd0;
          if (w_err && r_consec == 2'd2) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end
        end
        default: begin
          r_odd_err   <= 1'b0;
          r_step_err  <= 1'b0;
          r_wrap_up   <= 1'b0;
          r_wrap_down <= 1'b0;
          r_fault     <= 1'b1;
        end
      endcase
    end
  end
  assign bus.odd_err   = r_odd_err;
  assign bus.step_err  = r_step_err;
  assign bus.wrap_up   = r_wrap_up;
  assign bus.wrap_down = r_wrap_down;
  assign bus.err_count = r_err_count;
  assign bus.fault     = r_fault;
endmodule

// File: tb/tb_even_count_monitor.sv
// tb_even_count_monitor: scoreboard bench for even_count_monitor
module tb_even_count_monitor;
  logic clock = 1'b0;
  logic reset = 1'b1;
  even_count_monitor_if bus ();
  even_count_monitor dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  typedef struct packed {
    logic       oe;
    logic       se;
    logic       wu;
    logic       wd;
    logic [3:0] ec;
    logic       f;
  } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_wu = 0;
  int n_wd = 0;
  int n_se = 0;
  int m_st = 0;
  logic [3:0] m_prev = '0;
  logic       m_py = 1'b0;
  int         m_cons = 0;
  exp_t       m = '0;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask
  task automatic step(input logic rst, input logic [3:0] cnt, input logic dir);
    logic [3:0] e;
    logic       es;
    logic       er;
    exp_t       x;
    reset = rst;
    {bus.A, bus.B, bus.C, bus.D} = cnt;
    bus.y = dir;
    if (rst) begin
      m = '0; m_st = 0; m_prev = '0; m_py = 1'b0; m_cons = 0;
    end else if (m_st == 0) begin
      m.oe = cnt[0]; m_prev = cnt; m_py = dir; m_st = 1;
    end else if (m_st == 1) begin
      e = m_py ? m_prev + 4'd2 : m_prev - 4'd2;
      es = cnt != e;
      er = es | cnt[0];
      m.se = es;
      m.oe = cnt[0];
      m.wu = !er && m_py && m_prev == 4'd14 && cnt == 4'd0;
      m.wd = !er && !m_py && m_prev == 4'd0 && cnt == 4'd14;
      if (er) begin
        if (m.ec != 4'd15) m.ec = m.ec + 4'd1;
        m_cons++;
      end else m_cons = 0;
      if (m_cons == 3) begin m_st = 2; m.f = 1'b1; end
      m_prev = cnt; m_py = dir;
    end else begin
      m.oe = 0; m.se = 0; m.wu = 0; m.wd = 0; m.f = 1'b1;
    end
    exp_q.push_back(m);
    @(posedge clock);
    #1;
    x = exp_q.pop_front();
    check("odd_err", {7'b0, bus.odd_err}, {7'b0, x.oe});
    check("step_err", {7'b0, bus.step_err}, {7'b0, x.se});
    check("wrap_up", {7'b0, bus.wrap_up}, {7'b0, x.wu});
    check("wrap_down", {7'b0, bus.wrap_down}, {7'b0, x.wd});
    check("err_count", {4'b0, bus.err_count}, {4'b0, x.ec});
    check("fault", {7'b0, bus.fault}, {7'b0, x.f});
    n_wu += int'(bus.wrap_up);
    n_wd += int'(bus.wrap_down);
    n_se += int'(bus.step_err);
  endtask
  task automatic run(input logic [3:0] v[$], input logic dir);
    foreach (v[i]) step(1'b0, v[i], dir);
  endtask
  initial begin
    logic [3:0] c;
    step(1'b1, 4'd0, 1'b0);
    check("reset_all", {bus.odd_err, bus.step_err, bus.wrap_up, bus.wrap_down, bus.err_count}, 8'd0);
    n_wu = 0;
    run('{4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd0, 4'd2}, 1'b1);
    check("up_wraps", 8'(n_wu), 8'd1);
    check("up_errs", {4'b0, bus.err_count}, 8'd0);
    step(1'b1, 4'd0, 1'b0);
    n_wd = 0; n_wu = 0;
    run('{4'd4, 4'd2, 4'd0, 4'd14, 4'd12}, 1'b0);
    check("down_wraps", 8'(n_wd), 8'd1);
    check("down_errs", {4'b0, bus.err_count}, 8'd0);
    step(1'b1, 4'd0, 1'b0);
    n_se = 0;
    run('{4'd2, 4'd4, 4'd8, 4'd10, 4'd12}, 1'b1);
    check("inject_step", 8'(n_se), 8'd1);
    check("inject_cnt", {4'b0, bus.err_count}, 8'd1);
    step(1'b0, 4'd5, 1'b1);
    check("odd_both", {6'b0, bus.odd_err, bus.step_err}, 8'd3);
    check("odd_cnt", {4'b0, bus.err_count}, 8'd2);
    step(1'b1, 4'd0, 1'b0);
    run('{4'd0, 4'd2, 4'd8, 4'd0, 4'd6}, 1'b1);
    check("fault_set", {7'b0, bus.fault}, 8'd1);
    check("fault_cnt", {4'b0, bus.err_count}, 8'd3);
    run('{4'd8, 4'd10, 4'd3, 4'd12}, 1'b1);
    check("fault_hold", {bus.fault, bus.odd_err, bus.step_err, 1'b0, bus.err_count}, 8'h83);
    step(1'b1, 4'd0, 1'b0);
    check("fault_reset", {bus.fault, 3'b0, bus.err_count}, 8'd0);
    step(1'b0, 4'd0, 1'b1);
    c = 4'd0;
    for (int i = 0; i < 17; i++) begin
      c = c + 4'd6; step(1'b0, c, 1'b1);
      c = c + 4'd2; step(1'b0, c, 1'b1);
    end
    check("sat_cnt", {4'b0, bus.err_count}, 8'd15);
    check("sat_fault", {7'b0, bus.fault}, 8'd0);
    step(1'b1, 4'd0, 1'b1);
    run('{4'd0, 4'd4, 4'd8}, 1'b1);
    step(1'b1, 4'd12, 1'b1);
    check("rst_override", {bus.fault, 3'b0, bus.err_count}, 8'd0);
    if (exp_q.size() != 0) check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
